// File: rtl/blockram_stream_dma_pkg.sv
// Shared widths, state encoding and bus address helper for the block RAM stream DMA.
package blockram_stream_dma_pkg;

  localparam int unsigned WORD_ADR_W = 11;
  localparam int unsigned LEN_W      = 14;
  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_W     = 2;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned STATE_W    = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FILL  = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_FETCH = 3'd3;
  localparam state_t ST_DRAIN = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Byte address on the wishbone bus of a RAM word.
  function automatic logic [WORD_W-1:0] wb_byte_adr(input logic [WORD_W-1:0]     base,
                                                     input logic [WORD_ADR_W-1:0] word_adr);
    return base + WORD_W'({word_adr, 2'b00});
  endfunction

endpackage

// File: rtl/blockram_stream_dma_pack.sv
// 4-lane word register: lane-indexed packing for writes, right-shift unpacking for reads.
module byte_word_pack
  import blockram_stream_dma_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                push_i,
  input  logic [BYTE_W-1:0]   byte_i,
  input  logic                load_i,
  input  logic [WORD_W-1:0]   word_i,
  input  logic                shift_i,
  output logic [WORD_W-1:0]   data_o,
  output logic [LANE_W-1:0]   lane_o,
  output logic [LANES-1:0]    sel_d_o
);

  logic [WORD_W-1:0] data_q, data_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [LANES-1:0]  sel_q,  sel_d;

  // Read lanes are consumed from bits [7:0], so the current output byte is always a plain register slice.
  always_comb begin
    data_d = data_q;
    lane_d = lane_q;
    sel_d  = sel_q;
    if (clr_i) begin
      data_d = '0;
      lane_d = '0;
      sel_d  = '0;
    end else if (load_i) begin
      data_d = word_i;
      lane_d = '0;
      sel_d  = '0;
    end else if (push_i) begin
      data_d[{lane_q, 3'b000} +: BYTE_W] = byte_i;
      sel_d[lane_q] = 1'b1;
      lane_d        = lane_q + LANE_W'(1);
    end else if (shift_i) begin
      data_d = {BYTE_W'(0), data_q[WORD_W-1:BYTE_W]};
      lane_d = lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      lane_q <= '0;
      sel_q  <= '0;
    end else begin
      data_q <= data_d;
      lane_q <= lane_d;
      sel_q  <= sel_d;
    end
  end

  assign data_o  = data_q;
  assign lane_o  = lane_q;
  assign sel_d_o = sel_d;

endmodule

// File: rtl/blockram_stream_dma.sv
// Byte-stream DMA master for one block RAM wishbone port: packs a byte stream into RAM words or unpacks RAM words onto a byte stream.
module blockram_stream_dma
  import blockram_stream_dma_pkg::*;
#(
  parameter logic [31:0] ADR_BASE = 32'h0000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic                  dir_i,
  input  logic [WORD_ADR_W-1:0] adr_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [BYTE_W-1:0]     s_dat_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [BYTE_W-1:0]     m_dat_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [WORD_W-1:0]     wb_adr_o,
  output logic [WORD_W-1:0]     wb_dat_o,
  input  logic [WORD_W-1:0]     wb_dat_i,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [LANES-1:0]      wb_sel_o,
  input  logic                  wb_ack_i
);

  state_t                state_q, state_d;
  logic [WORD_ADR_W-1:0] word_adr_q, word_adr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [LANES-1:0]      sel_q, sel_d;
  logic [WORD_W-1:0]     adr_q, adr_d;

  logic                  pk_clr, pk_push, pk_load, pk_shift;
  logic [WORD_W-1:0]     pk_data;
  logic [LANE_W-1:0]     pk_lane;
  logic [LANES-1:0]      pk_sel_d;
  logic                  last_lane;
  logic [LEN_W-1:0]      rem_dec;

  byte_word_pack u_pack (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .clr_i   (pk_clr),
    .push_i  (pk_push),
    .byte_i  (s_dat_i),
    .load_i  (pk_load),
    .word_i  (wb_dat_i),
    .shift_i (pk_shift),
    .data_o  (pk_data),
    .lane_o  (pk_lane),
    .sel_d_o (pk_sel_d)
  );

  assign last_lane = (pk_lane == LANE_W'(LANES - 1));
  assign rem_dec   = (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;

  // Next state, address/count updates and packer controls.
  always_comb begin
    state_d    = state_q;
    word_adr_d = word_adr_q;
    rem_d      = rem_q;
    pk_clr     = 1'b0;
    pk_push    = 1'b0;
    pk_load    = 1'b0;
    pk_shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          word_adr_d = adr_i;
          rem_d      = len_i;
          pk_clr     = 1'b1;
          if (len_i == '0) begin
            state_d = ST_DONE;
          end else if (dir_i) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (s_valid_i && s_ready_q) begin
          pk_push = 1'b1;
          rem_d   = rem_dec;
          if (last_lane || rem_q <= LEN_W'(1)) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (wb_ack_i) begin
          word_adr_d = word_adr_q + WORD_ADR_W'(1);
          pk_clr     = 1'b1;
          state_d    = (rem_q == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FETCH: begin
        if (wb_ack_i) begin
          pk_load = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m_ready_i && m_valid_q) begin
          pk_shift = 1'b1;
          rem_d    = rem_dec;
          if (rem_q <= LEN_W'(1)) begin
            state_d = ST_DONE;
          end else if (last_lane) begin
            word_adr_d = word_adr_q + WORD_ADR_W'(1);
            state_d    = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    busy_d    = (state_d == ST_FILL) || (state_d == ST_WRITE) ||
                (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    done_d    = (state_d == ST_DONE);
    s_ready_d = (state_d == ST_FILL);
    m_valid_d = (state_d == ST_DRAIN);
    cyc_d     = (state_d == ST_WRITE) || (state_d == ST_FETCH);
    we_d      = (state_d == ST_WRITE);
    sel_d     = '0;
    if (state_d == ST_WRITE) begin
      sel_d = pk_sel_d;
    end else if (state_d == ST_FETCH) begin
      sel_d = '1;
    end
    adr_d     = wb_byte_adr(ADR_BASE, word_adr_d);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      word_adr_q <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
    end else begin
      state_q    <= state_d;
      word_adr_q <= word_adr_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign s_ready_o = s_ready_q;
  assign m_valid_o = m_valid_q;
  assign m_dat_o   = pk_data[BYTE_W-1:0];
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = pk_data;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;

endmodule

// File: doc/blockram_stream_dma.md
# blockram_stream_dma

Byte-stream DMA engine that masters one slave port of the 8 KB dual-clock-free block RAM. In write mode it packs an 8-bit valid/ready stream (e.g. SD/SPI data) into 32-bit words and writes them into RAM. In read mode it fetches words from RAM and unpacks them onto an 8-bit output stream. One transfer runs per start pulse, and a single wishbone master port feeds the RAM arbiter.

## Interface
- ADR_BASE, 32'h0000_0000, byte address of RAM word 0 on the wishbone bus
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse; latches dir_i/adr_i/len_i; ignored while busy_o=1
- dir_i  in  1  0 = stream→RAM (write), 1 = RAM→stream (read)
- adr_i  in  11  starting RAM word address
- len_i  in  14  byte count, 0..8192
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse at transfer end
- s_dat_i  in  8  input stream byte
- s_valid_i  in  1  input stream valid
- s_ready_o  out  1  input stream ready
- m_dat_o  out  8  output stream byte
- m_valid_o  out  1  output stream valid
- m_ready_i  in  1  output stream ready
- wb_adr_o  out  32  ADR_BASE + {word_adr, 2'b00}
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_sel_o  out  4  byte lanes
- wb_ack_i  in  1  slave acknowledge

## Operation
- FSM states are IDLE, FILL, WRITE, FETCH, DRAIN, DONE.
- IDLE: on start_i, latch the fields and set busy_o.
  - len=0 goes to DONE.
  - dir=0 goes to FILL.
  - dir=1 goes to FETCH.
- Byte k of a transfer maps to lane k mod 4. Lane 0 is bits [7:0].
- FILL: s_ready_o=1.
  - Each accepted byte (s_valid_i & s_ready_o) is stored in the next lane and its sel bit is set.
  - Move to WRITE when 4 bytes are held, or when the remaining count hits 0.
- WRITE: cyc=stb=we=1, wb_sel_o = the accumulated lanes (partial last word gives e.g. 4'b0011).
  - Unused lanes of wb_dat_o are 0.
  - On ack: word_adr+1, clear sel. If remaining=0 go to DONE, else FILL.
- FETCH: cyc=stb=1, we=0, sel=4'hF. On ack, capture wb_dat_i and go to DRAIN.
- DRAIN: m_valid_o=1, m_dat_o = the current lane.
  - Advance the lane and decrement remaining on m_ready_i.
  - After lane 3, or when remaining reaches 0: go to FETCH (word_adr+1) or DONE.
- DONE: done_o=1 for one cycle, busy_o=0, then IDLE.
- word_adr is 11 bits and wraps 2047→0 silently. The remaining counter is 14 bits and never underflows.
- wb_ack_i outside WRITE/FETCH is ignored.

## Timing
- Reset values: every output is 0; state=IDLE. Reset mid-transfer abandons it immediately and drops cyc/stb asynchronously, with no done_o.
- stb is held until ack, with no timeout (the arbiter may stall arbitrarily).
- The state leaves WRITE/FETCH on the ack edge, so stb is low the cycle after ack. The RAM's ack-gating requires this.
- Back-to-back operation:
  - FILL accepts 1 byte/cycle.
  - WRITE takes ≥2 cycles (stb, registered ack).
  - Steady-state write throughput is 4 bytes per ≥6 cycles.
- FETCH takes ≥2 cycles.
- m_valid_o is first asserted the cycle after ack. m_dat_o stays stable while m_valid_o & !m_ready_i.
- done_o is asserted the cycle after the final ack (write) or the final m_ready_i handshake (read).
- start_i on the same edge as done_o is ignored; start is accepted only in IDLE.

## Structure
- Shared package holds:
  - the state enum
  - WORD_ADR_W=11
  - LEN_W=14
  - LANES=4
- One natural sub-module, byte_word_pack: the 4-lane shift/hold register with lane counter and sel accumulator, shared by the pack and unpack paths.

## Test plan
- Write, len=8, adr=0x010, bytes 0x01..0x08 back-to-back:
  - two WRITEs with sel=F, data 0x04030201 then 0x08070605, at wb_adr 0x40 and 0x44
  - one done_o pulse
- Write, len=6: second WRITE has sel=4'b0011, dat_o=0x00000605.
- Read, len=5, RAM[0x7FF]=0xDDCCBBAA, RAM[0]=0x44332211:
  - stream AA BB CC DD 11
  - address wraps 0x1FFC→0x0000
- Read with m_ready_i toggling 1/0 every cycle, and ack delayed 5 cycles by arbiter contention: m_dat_o holds while stalled, no byte is lost or duplicated, stb stays high until ack.
- len=0 start: done_o on the following cycle, no cyc_o ever asserted. A start_i pulse while busy is ignored.
- Assert wb_rst_i mid-WRITE with stb high: cyc/stb drop immediately, busy_o=0, no done_o. A new len=4 transfer then completes normally.
